// File: rtl/diff_accumulator.sv
// diff_accumulator: sums difference pixels per digit template and picks the best match.
// Optional build macro DIFF_REJECT_EN: reject results whose best score exceeds REJECT_THRESHOLD.
module diff_accumulator #(
    parameter int unsigned NUM_TEMPLATES    = 10,
    parameter int unsigned PIX_PER_TEMPLATE = 121,
    parameter logic [15:0] REJECT_THRESHOLD = 16'd12000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  diff_pix,
    output logic        pix_ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit,
    output logic [15:0] score,
    output logic        digit_ok
);

    localparam int unsigned PW = (PIX_PER_TEMPLATE > 1) ? $clog2(PIX_PER_TEMPLATE) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_TEMPLATE - 1);
    localparam logic [3:0]    TMPL_LAST = 4'(NUM_TEMPLATES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   sum_q, sum_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [3:0]    tmpl_q, tmpl_d;
    logic [15:0]   best_q, best_d;
    logic [3:0]    bidx_q, bidx_d;
    logic [3:0]    digit_q, digit_d;
    logic [15:0]   score_q, score_d;
    logic          ok_q, ok_d;
    logic          accept_ok;

`ifdef DIFF_REJECT_EN
    assign accept_ok = (best_d <= REJECT_THRESHOLD);
`else
    logic unused_thr;
    assign unused_thr = ^REJECT_THRESHOLD;
    assign accept_ok  = 1'b1;
`endif

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        pix_d     = pix_q;
        tmpl_d    = tmpl_q;
        best_d    = best_q;
        bidx_d    = bidx_q;
        digit_d   = digit_q;
        score_d   = score_q;
        ok_d      = ok_q;
        pix_ready = 1'b0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    sum_d   = 16'd0;
                    pix_d   = '0;
                    tmpl_d  = 4'd0;
                    best_d  = 16'hFFFF;
                    bidx_d  = 4'd0;
                end
            end
            ACCUM: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    sum_d = sum_q + {8'd0, diff_pix};
                    if (pix_q == PIX_LAST) begin
                        pix_d   = '0;
                        state_d = COMPARE;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
            end
            COMPARE: begin
                sum_d = 16'd0;
                if (sum_q < best_q) begin
                    best_d = sum_q;
                    bidx_d = tmpl_q;
                end
                if (tmpl_q == TMPL_LAST) begin
                    state_d = DONE;
                    digit_d = bidx_d;
                    score_d = best_d;
                    ok_d    = accept_ok;
                end else begin
                    tmpl_d  = tmpl_q + 4'd1;
                    state_d = ACCUM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= 16'd0;
            pix_q   <= '0;
            tmpl_q  <= 4'd0;
            best_q  <= 16'hFFFF;
            bidx_q  <= 4'd0;
            digit_q <= 4'd0;
            score_q <= 16'd0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            pix_q   <= pix_d;
            tmpl_q  <= tmpl_d;
            best_q  <= best_d;
            bidx_q  <= bidx_d;
            digit_q <= digit_d;
            score_q <= score_d;
            ok_q    <= ok_d;
        end
    end

    assign digit    = digit_q;
    assign score    = score_q;
    assign digit_ok = ok_q;

endmodule

// File: tb/tb_diff_accumulator.sv
// tb_diff_accumulator: directed frames with a result scoreboard.
// Expected results come from a behavioural sum/argmin model.
module tb_diff_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_valid;
    logic [7:0]  diff_pix;
    logic        pix_ready;
    logic        busy;
    logic        done;
    logic [3:0]  digit;
    logic [15:0] score;
    logic        digit_ok;

    typedef struct {
        logic [3:0]  d;
        logic [15:0] s;
        logic        ok;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int NT = 10;
    localparam int NP = 121;

    diff_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .diff_pix  (diff_pix),
        .pix_ready (pix_ready),
        .busy      (busy),
        .done      (done),
        .digit     (digit),
        .score     (score),
        .digit_ok  (digit_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] val(input int mode, input int t, input int p);
        case (mode)
            0: return 8'd1;
            1: return (t == 7) ? 8'd0 : 8'd200;
            2: return 8'd255;
            3: return (t == 3) ? 8'(p % 5) : 8'(20 + ((p + t) % 9));
            4: return (t == 2 || t == 5) ? 8'd3 : 8'd4;
            default: return 8'd0;
        endcase
    endfunction

    function automatic exp_t model(input int mode);
        exp_t e;
        int   best;
        int   bi;
        best = 32'hFFFF;
        bi   = 0;
        for (int t = 0; t < NT; t++) begin
            int s;
            s = 0;
            for (int p = 0; p < NP; p++) s += val(mode, t, p);
            if (s < best) begin
                best = s;
                bi   = t;
            end
        end
        e.d = 4'(bi);
        e.s = 16'(best);
`ifdef DIFF_REJECT_EN
        e.ok = (best <= 12000);
`else
        e.ok = 1'b1;
`endif
        return e;
    endfunction

    // Runs one frame; abort_after > 0 stops feeding after that many pixels.
    task automatic run_frame(input int mode, input bit thr, input bit mid_start,
                             input bit start_in_done, input int abort_after);
        exp_t e;
        bit   tog;
        bit   acc;
        int   guard;
        int   fed;
        bit   pulsed;
        tog    = 1'b1;
        fed    = 0;
        pulsed = 1'b0;
        if (abort_after == 0) sb.push_back(model(mode));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int t = 0; t < NT; t++) begin
            for (int p = 0; p < NP; p++) begin
                if (abort_after > 0 && fed == abort_after) begin
                    pix_valid = 1'b0;
                    return;
                end
                acc   = 1'b0;
                guard = 0;
                while (!acc) begin
                    pix_valid = thr ? tog : 1'b1;
                    tog       = ~tog;
                    diff_pix  = val(mode, t, p);
                    start     = 1'b0;
                    if (mid_start && !pulsed && t == 4 && p == 60) begin
                        start  = 1'b1;
                        pulsed = 1'b1;
                    end
                    acc = pix_ready && pix_valid;
                    tick();
                    guard++;
                    if (guard > 20) begin
                        chk("pix_ready_timeout", 32'(guard), 32'd0);
                        pix_valid = 1'b0;
                        start     = 1'b0;
                        return;
                    end
                end
                fed++;
            end
            pix_valid = 1'b0;
            start     = 1'b0;
            chk("ready_in_compare", 32'(pix_ready), 32'd0);
        end
        chk("done_latency_early", 32'(done), 32'd0);
        if (start_in_done) begin
            tick();
            start = 1'b1;
        end else begin
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("digit", 32'(digit), 32'(e.d));
            chk("score", 32'(score), 32'(e.s));
            chk("digit_ok", 32'(digit_ok), 32'(e.ok));
        end
        tick();
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("digit_hold", 32'(digit), 32'(e.d));
        chk("score_hold", 32'(score), 32'(e.s));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        diff_pix  = 8'd0;
        tick();
        tick();
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_digit_ok", 32'(digit_ok), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_beats_start", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        run_frame(0, 1'b0, 1'b0, 1'b0, 0);
        run_frame(1, 1'b0, 1'b0, 1'b1, 0);
        run_frame(2, 1'b0, 1'b0, 1'b0, 0);
        run_frame(1, 1'b1, 1'b1, 1'b0, 0);
        run_frame(4, 1'b0, 1'b0, 1'b0, 0);

        run_frame(1, 1'b0, 1'b0, 1'b0, 600);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_pix_ready", 32'(pix_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_digit", 32'(digit), 32'd0);
        chk("abort_score", 32'(score), 32'd0);
        chk("abort_digit_ok", 32'(digit_ok), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_frame(3, 1'b0, 1'b0, 1'b0, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/diff_accumulator.md
DIFF_ACCUMULATOR -- requirements
Module: diff_accumulator

Interface
REQ-001 Parameter NUM_TEMPLATES, default 10: number of digit templates scored per frame (digits 0..9).
REQ-002 Parameter PIX_PER_TEMPLATE, default 121: difference pixels per template (11x11, row-major).
REQ-003 Parameter REJECT_THRESHOLD, default 16'd12000: maximum accepted best score (used only with REQ-027).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-007 pix_valid  input  1  diff_pix carries a valid difference pixel.
REQ-008 diff_pix  input  8  unsigned difference pixel from the per-template difference stage.
REQ-009 pix_ready  output  1  block accepts a pixel this cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; result outputs valid.
REQ-012 digit  output  4  index of the lowest-scoring template.
REQ-013 score  output  16  sum of diff_pix over the winning template.
REQ-014 digit_ok  output  1  recognition accepted.

Function
REQ-015 States: IDLE, ACCUM, COMPARE, DONE.
- IDLE -> ACCUM on start: clear sum, pixel counter and template counter; set best to 16'hFFFF and best_idx to 0.
REQ-016 pix_ready = 1 only in ACCUM; a pixel is accepted when pix_valid and pix_ready are both 1; pix_valid in any other state is ignored.
REQ-017 On each accepted pixel: sum += zero-extended diff_pix (16 bit); pixel counter increments.
- Maximum sum 121*255 = 30855; no overflow.
REQ-018 When the accepted pixel is number PIX_PER_TEMPLATE: pixel counter resets to 0 and the state moves to COMPARE; no pixel is accepted in COMPARE.
REQ-019 In COMPARE, if sum < best (strict): best = sum and best_idx = template counter.
- Ties keep the lower index.
- sum clears to 0.
REQ-020 From COMPARE: if the template counter = NUM_TEMPLATES-1, go to DONE; otherwise increment the template counter and return to ACCUM.
REQ-021 In DONE: digit = best_idx, score = best and digit_ok are registered; done = 1 for exactly that cycle; next state IDLE.
REQ-022 digit, score and digit_ok hold their value until the next DONE or reset.
REQ-023 Latency: done asserts 2 cycles after the cycle in which the final pixel of the final template is accepted.
REQ-024 start while busy = 1 is ignored, including start in the DONE cycle.
- start in the cycle after done begins a new frame normally.
REQ-025 Gaps with pix_valid = 0 in ACCUM stall accumulation without changing the counters or the sum.

Reset
REQ-026 When reset = 1, on the next clock edge:
- state goes to IDLE.
- pix_ready = 0, busy = 0, done = 0, digit = 0, score = 0, digit_ok = 0.
- all counters and sums clear and best = 16'hFFFF.
- a reset in the middle of a frame aborts it with no done pulse.
- reset takes priority over start.

Configuration
REQ-027 Macro DIFF_REJECT_EN:
- Defined: digit_ok = 1 in DONE only if best <= REJECT_THRESHOLD, otherwise 0.
- Undefined: digit_ok = 1 in every DONE cycle, and REJECT_THRESHOLD has no effect.

Verification
REQ-028 Uniform frame:
- Stimulus: start, then all 1210 pixels = 1 with pix_valid held high.
- Required: done exactly 2 cycles after the last pixel; digit = 0 (tie rule); score = 121.
REQ-029 Single winner:
- Stimulus: template 7 all 0; all other templates all 200.
- Required: digit = 7; score = 0; digit_ok = 1.
REQ-030 Maximum and threshold:
- Stimulus: every pixel = 255.
- Required: score = 30855; digit = 0.
- With DIFF_REJECT_EN defined: digit_ok = 0.
- Without DIFF_REJECT_EN: digit_ok = 1.
REQ-031 Throttling:
- Stimulus: pix_valid toggling 1/0; start pulsed mid-frame.
- Required: result identical to REQ-029; the mid-frame start has no effect; pix_ready = 0 in every COMPARE cycle.
REQ-032 Abort:
- Stimulus: reset asserted after 600 pixels.
- Required: no done; all outputs are 0 on the next cycle.
- A new frame after the reset completes correctly with digit = 3 when template 3 has the lowest sum.
